// File: rtl/axis_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// axis_uart_rx_fifo
//
// Parametrised UART receiver feeding a first-word-fall-through FIFO on an
// AXI-Stream master port. The line is oversampled 16x. Each bit is the
// majority of samples 7, 8 and 9. A start bit that is not still low at its
// mid-point is rejected as a glitch. Every completed frame is pushed with
// its parity/framing flags. If the FIFO is full, the word is dropped and
// 'overrun' pulses for one cycle.
//
// Ports:
//   aclk          - clock
//   areset        - synchronous active-high reset
//   uart_rx       - asynchronous serial input, idle high
//   m_axis_tdata  - received word, LSB = first bit on the line
//   m_axis_tuser  - [0] parity error, [1] framing error
//   m_axis_tvalid - FIFO not empty
//   m_axis_tready - downstream ready
//   overrun       - one-cycle pulse when a completed word is dropped
//   fifo_level    - number of words currently stored
// ----------------------------------------------------------------------------
module axis_uart_rx_fifo #(
    parameter int CLOCK     = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     uart_rx,
    output logic [DATA_BITS-1:0]     m_axis_tdata,
    output logic [1:0]               m_axis_tuser,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    // Rounded divider from aclk to the 16x oversampling tick.
    localparam int DIV = (CLOCK + 8 * BAUD_RATE) / (16 * BAUD_RATE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int WW  = DATA_BITS + 2;

    localparam logic [TW-1:0] TICK_LAST  = TW'(DIV - 1);
    localparam logic [AW:0]   DEPTH_LVL  = (AW + 1)'(DEPTH);
    localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic          ODD_PARITY = (PARITY == 1);
    localparam logic          HAS_PARITY = (PARITY != 0);

    typedef enum logic [2:0] {
        ST_WAIT_HIGH,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Error when the data/parity ones-count does not match the selected mode.
    function automatic logic parity_error(input logic [DATA_BITS-1:0] data, input logic pbit);
        return ((^data) ^ pbit) != ODD_PARITY;
    endfunction

    // ---------------- synchroniser / edge detect / tick ---------------------
    logic [1:0]    sync_r;
    logic          rx_prev_r;
    logic [1:0]    settle_r;
    logic          rx_s;
    logic          fall_s;
    logic [TW-1:0] tick_cnt_r;
    logic          tick_s;

    state_t                 state_r;
    logic [3:0]             samp_cnt_r;
    logic                   s7_r;
    logic                   s8_r;
    logic [DATA_BITS-1:0]   shreg_r;
    logic [3:0]             bit_cnt_r;
    logic                   perr_r;
    logic                   ferr_r;
    logic                   vote_s;
    logic                   vote_tick_s;
    logic                   push_req_s;
    logic [WW-1:0]          word_s;

    assign rx_s        = sync_r[1];
    assign fall_s      = rx_prev_r & ~rx_s;
    assign tick_s      = (tick_cnt_r == TICK_LAST);
    assign vote_tick_s = tick_s & (samp_cnt_r == 4'd9);
    assign vote_s      = majority3(s7_r, s8_r, rx_s);

    // Two-flop synchroniser (preset high) plus one delayed copy for edge detection.
    // settle_r keeps WAIT_HIGH from trusting the preset value before the
    // chain has been refilled from the pin after a reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            sync_r    <= 2'b11;
            rx_prev_r <= 1'b1;
            settle_r  <= 2'b00;
        end else begin
            sync_r    <= {sync_r[0], uart_rx};
            rx_prev_r <= rx_s;
            settle_r  <= {settle_r[0], 1'b1};
        end
    end

    // Oversampling tick counter; realigned to the detected start edge.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tick_cnt_r <= TW'(0);
        end else if ((state_r == ST_IDLE) && fall_s) begin
            tick_cnt_r <= TW'(0);
        end else if (tick_s) begin
            tick_cnt_r <= TW'(0);
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // The frame is pushed on the last stop-bit vote, so the FIFO sees it
    // in the same cycle and tvalid can rise on the next one.
    assign push_req_s = (state_r == ST_STOP) && vote_tick_s && (bit_cnt_r == STOP_LAST);
    assign word_s     = {ferr_r | ~vote_s, perr_r, shreg_r};

    // Receiver FSM with its sample, shift and error registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r    <= ST_WAIT_HIGH;
            samp_cnt_r <= 4'd0;
            s7_r       <= 1'b1;
            s8_r       <= 1'b1;
            shreg_r    <= {DATA_BITS{1'b0}};
            bit_cnt_r  <= 4'd0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
        end else begin
            if (tick_s) begin
                samp_cnt_r <= samp_cnt_r + 4'd1;
                if (samp_cnt_r == 4'd7) begin
                    s7_r <= rx_s;
                end else if (samp_cnt_r == 4'd8) begin
                    s8_r <= rx_s;
                end
            end
            case (state_r)
                ST_WAIT_HIGH: begin
                    if (settle_r[1] && rx_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (fall_s) begin
                        state_r    <= ST_START;
                        samp_cnt_r <= 4'd0;
                    end
                end
                ST_START: begin
                    if (vote_tick_s) begin
                        if (!vote_s) begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= 4'd0;
                            perr_r    <= 1'b0;
                            ferr_r    <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (vote_tick_s) begin
                        shreg_r <= {vote_s, shreg_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_r <= 4'd0;
                            if (HAS_PARITY) begin
                                state_r <= ST_PARITY;
                            end else begin
                                state_r <= ST_STOP;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (vote_tick_s) begin
                        perr_r    <= parity_error(shreg_r, vote_s);
                        bit_cnt_r <= 4'd0;
                        state_r   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (vote_tick_s) begin
                        if (bit_cnt_r == STOP_LAST) begin
                            bit_cnt_r <= 4'd0;
                            // A low last stop bit means break/low line: wait for idle.
                            if (vote_s) begin
                                state_r <= ST_IDLE;
                            end else begin
                                state_r <= ST_WAIT_HIGH;
                            end
                        end else begin
                            ferr_r    <= ferr_r | ~vote_s;
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_WAIT_HIGH;
                end
            endcase
        end
    end

    // ---------------- FWFT FIFO ---------------------------------------------
    logic [WW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          tvalid_r;
    logic [WW-1:0] head_r;
    logic          overrun_r;

    logic          pop_s;
    logic          full_s;
    logic          push_ok_s;
    logic [AW:0]   count_nxt_s;
    logic [AW-1:0] rd_ptr_inc_s;
    logic [WW-1:0] head_nxt_s;

    // Next-state for level and the registered head word. The head is taken
    // straight from the incoming word when it becomes the only entry, since
    // the memory slot is not written until the same edge.
    always_comb begin
        pop_s        = tvalid_r & m_axis_tready;
        full_s       = (count_r == DEPTH_LVL);
        push_ok_s    = push_req_s & (~full_s | pop_s);
        count_nxt_s  = count_r + (AW + 1)'(push_ok_s) - (AW + 1)'(pop_s);
        rd_ptr_inc_s = rd_ptr_r + AW'(1);
        head_nxt_s   = head_r;
        if (push_ok_s && ((count_r == (AW + 1)'(0)) || (pop_s && (count_r == (AW + 1)'(1))))) begin
            head_nxt_s = word_s;
        end else if (pop_s && (count_r > (AW + 1)'(1))) begin
            head_nxt_s = mem_r[rd_ptr_inc_s];
        end else begin
            head_nxt_s = head_r;
        end
    end

    // FIFO storage; contents need no reset because pointers and level do.
    always_ff @(posedge aclk) begin
        if (push_ok_s && !areset) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    // FIFO pointers, level and registered AXIS outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_r  <= AW'(0);
            rd_ptr_r  <= AW'(0);
            count_r   <= (AW + 1)'(0);
            tvalid_r  <= 1'b0;
            head_r    <= {WW{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            count_r   <= count_nxt_s;
            tvalid_r  <= (count_nxt_s != (AW + 1)'(0));
            head_r    <= head_nxt_s;
            overrun_r <= push_req_s & full_s & ~pop_s;
        end
    end

    assign m_axis_tdata  = head_r[DATA_BITS-1:0];
    assign m_axis_tuser  = head_r[WW-1:DATA_BITS];
    assign m_axis_tvalid = tvalid_r;
    assign overrun       = overrun_r;
    assign fifo_level    = count_r;

endmodule

// File: tb/tb_axis_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_axis_uart_rx_fifo
//
// Directed bench. Three receivers share one clock:
//   u_def  - all defaults (8N1, 115200 baud): basic frame and glitch cases
//   u_par  - even parity, two stop bits, fast baud: parity flag cases
//   u_fast - 8N1, fast baud: framing/break, overrun/drain and reset cases
// At the fast rate the divider is 4, so one bit lasts 64 clocks.
// ----------------------------------------------------------------------------
module tb_axis_uart_rx_fifo;

    localparam int BAUD_FAST = 1_562_500;
    localparam int BP_DEF    = 16 * 54;
    localparam int BP_FAST   = 16 * 4;

    logic       aclk;
    logic [2:0] rst;
    logic       rx0, rx1, rx2;
    logic [2:0] rdy;
    logic [7:0] tdata0, tdata1, tdata2;
    logic [1:0] tuser0, tuser1, tuser2;
    logic       vld0, vld1, vld2;
    logic       ovr0, ovr1, ovr2;
    logic [4:0] lvl0, lvl1, lvl2;

    int n_checks;
    int n_fail;
    int ovr_cnt2;
    int ovr_base;
    int got;

    axis_uart_rx_fifo u_def (
        .aclk(aclk), .areset(rst[0]), .uart_rx(rx0),
        .m_axis_tdata(tdata0), .m_axis_tuser(tuser0), .m_axis_tvalid(vld0),
        .m_axis_tready(rdy[0]), .overrun(ovr0), .fifo_level(lvl0)
    );

    axis_uart_rx_fifo #(.BAUD_RATE(BAUD_FAST), .PARITY(2), .STOP_BITS(2)) u_par (
        .aclk(aclk), .areset(rst[1]), .uart_rx(rx1),
        .m_axis_tdata(tdata1), .m_axis_tuser(tuser1), .m_axis_tvalid(vld1),
        .m_axis_tready(rdy[1]), .overrun(ovr1), .fifo_level(lvl1)
    );

    axis_uart_rx_fifo #(.BAUD_RATE(BAUD_FAST)) u_fast (
        .aclk(aclk), .areset(rst[2]), .uart_rx(rx2),
        .m_axis_tdata(tdata2), .m_axis_tuser(tuser2), .m_axis_tvalid(vld2),
        .m_axis_tready(rdy[2]), .overrun(ovr2), .fifo_level(lvl2)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Count overrun pulses from the fast receiver.
    always @(negedge aclk) begin
        if (ovr2) ovr_cnt2 <= ovr_cnt2 + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int ch, input logic v);
        case (ch)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // One frame: start, 8 data bits LSB first, optional parity, stop bits.
    // The line is left at the stop-bit value.
    task automatic send_frame(input int ch, input logic [7:0] d, input int has_par,
                              input logic pbit, input int nstop, input logic stopv);
        int bp;
        bp = (ch == 0) ? BP_DEF : BP_FAST;
        @(negedge aclk);
        drive(ch, 1'b0);
        repeat (bp) @(negedge aclk);
        for (int i = 0; i < 8; i++) begin
            drive(ch, d[i]);
            repeat (bp) @(negedge aclk);
        end
        if (has_par != 0) begin
            drive(ch, pbit);
            repeat (bp) @(negedge aclk);
        end
        for (int i = 0; i < nstop; i++) begin
            drive(ch, stopv);
            repeat (bp) @(negedge aclk);
        end
    endtask

    // Check the head beat of channel 1 or 2, then pop it with one tready cycle.
    task automatic pop_check(input int ch, input string tag, input logic [7:0] ed, input logic [1:0] eu);
        logic       v;
        logic [7:0] d;
        logic [1:0] u;
        @(negedge aclk);
        if (ch == 1) begin
            v = vld1; d = tdata1; u = tuser1;
        end else begin
            v = vld2; d = tdata2; u = tuser2;
        end
        check_val({tag, "_tvalid"}, {31'd0, v}, 32'd1);
        check_val({tag, "_tdata"}, {24'd0, d}, {24'd0, ed});
        check_val({tag, "_tuser"}, {30'd0, u}, {30'd0, eu});
        rdy[ch] = 1'b1;
        @(negedge aclk);
        rdy[ch] = 1'b0;
    endtask

    initial begin
        repeat (150000) @(posedge aclk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ovr_cnt2 = 0;
        rst = 3'b111;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        rdy = 3'b000;
        repeat (4) @(negedge aclk);

        // Reset state: {tvalid, overrun, level, tuser, tdata} all zero.
        check_val("rst_def",  {15'd0, vld0, ovr0, lvl0, tuser0, tdata0}, 32'd0);
        check_val("rst_par",  {15'd0, vld1, ovr1, lvl1, tuser1, tdata1}, 32'd0);
        check_val("rst_fast", {15'd0, vld2, ovr2, lvl2, tuser2, tdata2}, 32'd0);
        rst = 3'b000;
        repeat (20) @(negedge aclk);

        // 1: 8N1 frame 0xA5 at default rate, tready held high.
        rdy[0] = 1'b1;
        fork
            send_frame(0, 8'hA5, 0, 1'b0, 1, 1'b1);
            begin
                got = 0;
                for (int i = 0; i < 12000; i++) begin
                    @(negedge aclk);
                    if (vld0) begin
                        got = 1;
                        break;
                    end
                end
                check_val("t1_beat_seen", got, 32'd1);
                check_val("t1_tdata", {24'd0, tdata0}, 32'hA5);
                check_val("t1_tuser", {30'd0, tuser0}, 32'd0);
                @(negedge aclk);
                check_val("t1_tvalid_after", {31'd0, vld0}, 32'd0);
            end
        join
        rdy[0] = 1'b0;

        // 4: 2 us glitch on the idle line.
        drive(0, 1'b0);
        repeat (200) @(negedge aclk);
        drive(0, 1'b1);
        repeat (2000) @(negedge aclk);
        check_val("t4_tvalid", {31'd0, vld0}, 32'd0);
        check_val("t4_level", {27'd0, lvl0}, 32'd0);

        // 2: even parity, 0x07 has three ones.
        send_frame(1, 8'h07, 1, 1'b0, 2, 1'b1);
        check_val("t2_level", {27'd0, lvl1}, 32'd1);
        pop_check(1, "t2_bad", 8'h07, 2'b01);
        send_frame(1, 8'h07, 1, 1'b1, 2, 1'b1);
        pop_check(1, "t2_good", 8'h07, 2'b00);
        check_val("t2_level_end", {27'd0, lvl1}, 32'd0);

        // 3: framing error, held break, then a clean frame.
        send_frame(2, 8'h55, 0, 1'b0, 1, 1'b0);
        repeat (3 * BP_FAST) @(negedge aclk);
        drive(2, 1'b1);
        repeat (2 * BP_FAST) @(negedge aclk);
        check_val("t3_level_break", {27'd0, lvl2}, 32'd1);
        send_frame(2, 8'h3C, 0, 1'b0, 1, 1'b1);
        check_val("t3_level", {27'd0, lvl2}, 32'd2);
        pop_check(2, "t3_ferr", 8'h55, 2'b10);
        pop_check(2, "t3_clean", 8'h3C, 2'b00);

        // 5: fill to 16, one overrun on the 17th, head held, then drain.
        ovr_base = ovr_cnt2;
        for (int i = 1; i <= 16; i++) begin
            send_frame(2, 8'(i), 0, 1'b0, 1, 1'b1);
        end
        check_val("t5_level_full", {27'd0, lvl2}, 32'd16);
        check_val("t5_no_ovr_yet", ovr_cnt2 - ovr_base, 32'd0);
        send_frame(2, 8'h11, 0, 1'b0, 1, 1'b1);
        repeat (10) @(negedge aclk);
        check_val("t5_ovr_count", ovr_cnt2 - ovr_base, 32'd1);
        check_val("t5_level_after", {27'd0, lvl2}, 32'd16);
        check_val("t5_head_held", {23'd0, vld2, tdata2}, {23'd0, 1'b1, 8'h01});
        rdy[2] = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check_val("t5_drain", {23'd0, vld2, tdata2}, {23'd0, 1'b1, 8'(i)});
            @(negedge aclk);
        end
        rdy[2] = 1'b0;
        check_val("t5_level_empty", {27'd0, lvl2}, 32'd0);
        check_val("t5_tvalid_empty", {31'd0, vld2}, 32'd0);

        // 6: reset during data bit 4 with one word already queued.
        send_frame(2, 8'h99, 0, 1'b0, 1, 1'b1);
        check_val("t6_level_pre", {27'd0, lvl2}, 32'd1);
        fork
            send_frame(2, 8'hC3, 0, 1'b0, 1, 1'b1);
            begin
                repeat (5 * BP_FAST + BP_FAST / 2) @(negedge aclk);
                rst[2] = 1'b1;
                @(negedge aclk);
                rst[2] = 1'b0;
            end
        join
        repeat (2 * BP_FAST) @(negedge aclk);
        check_val("t6_tvalid", {31'd0, vld2}, 32'd0);
        check_val("t6_level", {27'd0, lvl2}, 32'd0);
        send_frame(2, 8'hC3, 0, 1'b0, 1, 1'b1);
        check_val("t6_level_post", {27'd0, lvl2}, 32'd1);
        pop_check(2, "t6_next", 8'hC3, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
